// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined RV32 immediate generator: format codes,
// opcode constants and the opcode-to-format decode helper.
package imm_pkg;

    localparam int INSTR_W = 32;
    localparam int FMT_W   = 3;

    typedef enum logic [FMT_W-1:0] {
        FMT_I   = 3'd0,
        FMT_S   = 3'd1,
        FMT_B   = 3'd2,
        FMT_U   = 3'd3,
        FMT_J   = 3'd4,
        FMT_R   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    function automatic fmt_e decode_fmt(input logic [6:0] opc);
        fmt_e f;
        case (opc)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: f = FMT_I;
            OP_STORE:                            f = FMT_S;
            OP_BRANCH:                           f = FMT_B;
            OP_LUI, OP_AUIPC:                    f = FMT_U;
            OP_JAL:                              f = FMT_J;
            OP_REG:                              f = FMT_R;
            default:                             f = FMT_ILL;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: decodes the format from the opcode, assembles
// and sign-extends the immediate, and forms the branch/jump target pc+imm.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INSTR_W-1:0] instr,
    input  logic [XLEN-1:0]    pc,
    output logic [FMT_W-1:0]   fmt,
    output logic               illegal,
    output logic [XLEN-1:0]    imm,
    output logic [XLEN-1:0]    target
);

    fmt_e              fmt_s;
    logic [31:0]       imm32_s;
    logic [XLEN-1:0]   imm_s;

    // Format decode and 32-bit immediate assembly (bit 31 is always the sign).
    always_comb begin
        fmt_s   = decode_fmt(instr[6:0]);
        imm32_s = 32'd0;
        case (fmt_s)
            FMT_I:   imm32_s = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0};
            FMT_U:   imm32_s = {instr[31:12], 12'd0};
            FMT_J:   imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                instr[30:21], 1'b0};
            default: imm32_s = 32'd0;
        endcase
    end

    assign imm_s   = XLEN'($signed(imm32_s));
    assign imm     = imm_s;
    assign fmt     = fmt_s;
    assign illegal = (fmt_s == FMT_ILL);
    assign target  = ((fmt_s == FMT_B) || (fmt_s == FMT_J)) ? (pc + imm_s) : {XLEN{1'b0}};

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32 immediate generator with valid/ready on both sides. Main register M
// drives the outputs; with SKID_EN a second register K absorbs one result under stall.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SKID_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_imm,
    output logic [XLEN-1:0]    out_target,
    output logic [FMT_W-1:0]   out_fmt,
    output logic               out_illegal
);

    logic [FMT_W-1:0] ex_fmt_s;
    logic             ex_illegal_s;
    logic [XLEN-1:0]  ex_imm_s;
    logic [XLEN-1:0]  ex_target_s;

    logic             in_ready_s;
    logic             in_fire_s;
    logic             m_drain_s;

    logic             k_valid_s;
    logic [FMT_W-1:0] k_fmt_s;
    logic             k_illegal_s;
    logic [XLEN-1:0]  k_imm_s;
    logic [XLEN-1:0]  k_target_s;

    logic             m_valid_r;
    logic [FMT_W-1:0] m_fmt_r;
    logic             m_illegal_r;
    logic [XLEN-1:0]  m_imm_r;
    logic [XLEN-1:0]  m_target_r;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr   (in_instr),
        .pc      (in_pc),
        .fmt     (ex_fmt_s),
        .illegal (ex_illegal_s),
        .imm     (ex_imm_s),
        .target  (ex_target_s)
    );

    assign m_drain_s = !m_valid_r || out_ready;
    assign in_fire_s = in_valid && in_ready_s;

    generate
        if (SKID_EN != 0) begin : g_skid
            logic             k_valid_r;
            logic [FMT_W-1:0] k_fmt_r;
            logic             k_illegal_r;
            logic [XLEN-1:0]  k_imm_r;
            logic [XLEN-1:0]  k_target_r;

            // K catches an accepted result while M is stalled; it empties into M on drain.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    k_valid_r   <= 1'b0;
                    k_fmt_r     <= {FMT_W{1'b0}};
                    k_illegal_r <= 1'b0;
                    k_imm_r     <= {XLEN{1'b0}};
                    k_target_r  <= {XLEN{1'b0}};
                end else if (m_drain_s) begin
                    k_valid_r   <= 1'b0;
                end else if (in_fire_s) begin
                    k_valid_r   <= 1'b1;
                    k_fmt_r     <= ex_fmt_s;
                    k_illegal_r <= ex_illegal_s;
                    k_imm_r     <= ex_imm_s;
                    k_target_r  <= ex_target_s;
                end
            end

            assign in_ready_s  = !k_valid_r;
            assign k_valid_s   = k_valid_r;
            assign k_fmt_s     = k_fmt_r;
            assign k_illegal_s = k_illegal_r;
            assign k_imm_s     = k_imm_r;
            assign k_target_s  = k_target_r;
        end else begin : g_noskid
            assign in_ready_s  = m_drain_s;
            assign k_valid_s   = 1'b0;
            assign k_fmt_s     = {FMT_W{1'b0}};
            assign k_illegal_s = 1'b0;
            assign k_imm_s     = {XLEN{1'b0}};
            assign k_target_s  = {XLEN{1'b0}};
        end
    endgenerate

    // M refills on drain, oldest first: K has priority over a fresh input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_r   <= 1'b0;
            m_fmt_r     <= {FMT_W{1'b0}};
            m_illegal_r <= 1'b0;
            m_imm_r     <= {XLEN{1'b0}};
            m_target_r  <= {XLEN{1'b0}};
        end else if (m_drain_s) begin
            if (k_valid_s) begin
                m_valid_r   <= 1'b1;
                m_fmt_r     <= k_fmt_s;
                m_illegal_r <= k_illegal_s;
                m_imm_r     <= k_imm_s;
                m_target_r  <= k_target_s;
            end else if (in_fire_s) begin
                m_valid_r   <= 1'b1;
                m_fmt_r     <= ex_fmt_s;
                m_illegal_r <= ex_illegal_s;
                m_imm_r     <= ex_imm_s;
                m_target_r  <= ex_target_s;
            end else begin
                m_valid_r   <= 1'b0;
            end
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = m_valid_r;
    assign out_fmt     = m_fmt_r;
    assign out_illegal = m_illegal_r;
    assign out_imm     = m_imm_r;
    assign out_target  = m_target_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed vectors, backpressure, throughput,
// randomized traffic against an arithmetic reference model, and mid-stream reset.
module tb_imm_gen_pipe;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_target;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    typedef struct {
        logic [31:0] imm;
        logic [31:0] tgt;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_pop  = 0;
    int   pop0;
    logic [6:0] ops [0:11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                               7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h0B};

    imm_gen_pipe #(.XLEN(XLEN), .SKID_EN(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_target  (out_target),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    // Reference: immediates as weighted field sums minus the sign weight.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic [31:0] sgn;
        sgn   = ins[31] ? 32'hFFFF_FFFF : 32'd0;
        e.imm = 32'd0;
        e.tgt = 32'd0;
        e.fmt = 3'd7;
        e.ill = 1'b1;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: begin
                e.fmt = 3'd0;
                e.imm = 32'(ins[31:20]) - (sgn & 32'd4096);
            end
            7'h23: begin
                e.fmt = 3'd1;
                e.imm = 32'(ins[31:25]) * 32'd32 + 32'(ins[11:7]) - (sgn & 32'd4096);
            end
            7'h63: begin
                e.fmt = 3'd2;
                e.imm = 32'(ins[7]) * 32'd2048 + 32'(ins[30:25]) * 32'd32
                      + 32'(ins[11:8]) * 32'd2 - (sgn & 32'd4096);
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd3;
                e.imm = 32'(ins[31:12]) * 32'd4096;
            end
            7'h6F: begin
                e.fmt = 3'd4;
                e.imm = 32'(ins[19:12]) * 32'd4096 + 32'(ins[20]) * 32'd2048
                      + 32'(ins[30:21]) * 32'd2 - (sgn & 32'h0010_0000);
            end
            7'h33: e.fmt = 3'd5;
            default: e.fmt = 3'd7;
        endcase
        e.ill = (e.fmt == 3'd7);
        if (e.fmt == 3'd2 || e.fmt == 3'd4) e.tgt = pc + e.imm;
        return e;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        r = $urandom;
        return {r[31:7], ops[$urandom_range(0, 11)]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: score outputs and accepted inputs at negedge, return just after posedge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("stale_out", 32'(out_valid), 32'd0);
            end else begin
                e = q[0];
                chk("sb_imm", out_imm, e.imm);
                chk("sb_tgt", out_target, e.tgt);
                chk("sb_fmt", 32'(out_fmt), 32'(e.fmt));
                chk("sb_ill", 32'(out_illegal), 32'(e.ill));
                if (out_ready === 1'b1) begin
                    void'(q.pop_front());
                    n_pop++;
                end
            end
        end
        if (in_valid === 1'b1 && in_ready === 1'b1) q.push_back(model(in_instr, in_pc));
        @(posedge clk);
        #1;
    endtask

    task automatic dir(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] eimm, input logic [31:0] etgt,
                       input logic [2:0] efmt, input logic eill);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = ins;
        in_pc     = pc;
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_imm"}, out_imm, eimm);
        chk({tag, "_tgt"}, out_target, etgt);
        chk({tag, "_fmt"}, 32'(out_fmt), 32'(efmt));
        chk({tag, "_ill"}, 32'(out_illegal), 32'(eill));
        @(posedge clk);
        #1;
        chk({tag, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = 32'd0;
        in_pc     = 32'd0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_tgt", out_target, 32'd0);
        chk("rst_fmt", 32'(out_fmt), 32'd0);
        chk("rst_ill", 32'(out_illegal), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        dir("b",   32'hFE000EE3, 32'h100, 32'hFFFFFFFC, 32'h000000FC, 3'd2, 1'b0);
        dir("j",   32'h008000EF, 32'h200, 32'h00000008, 32'h00000208, 3'd4, 1'b0);
        dir("u",   32'h123452B7, 32'h300, 32'h12345000, 32'h00000000, 3'd3, 1'b0);
        dir("i",   32'hFFF00093, 32'h400, 32'hFFFFFFFF, 32'h00000000, 3'd0, 1'b0);
        dir("s",   32'hFE20AC23, 32'h500, 32'hFFFFFFF8, 32'h00000000, 3'd1, 1'b0);
        dir("ill", 32'h0000007F, 32'h600, 32'h00000000, 32'h00000000, 3'd7, 1'b1);

        // Backpressure: two accepted, third refused, then all three drain back-to-back.
        pop0      = n_pop;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = rnd_instr();
        in_pc     = $urandom;
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        cyc();
        in_instr = rnd_instr();
        in_pc    = $urandom;
        chk("bp_rdy2", 32'(in_ready), 32'd1);
        cyc();
        in_instr = rnd_instr();
        in_pc    = $urandom;
        chk("bp_rdy3", 32'(in_ready), 32'd0);
        repeat (3) cyc();
        chk("bp_held", 32'(q.size()), 32'd2);
        out_ready = 1'b1;
        cyc();
        chk("bp_gap1", 32'(out_valid), 32'd1);
        cyc();
        in_valid = 1'b0;
        chk("bp_gap2", 32'(out_valid), 32'd1);
        cyc();
        chk("bp_done", 32'(out_valid), 32'd0);
        chk("bp_count", 32'(n_pop - pop0), 32'd3);

        // Throughput: 16 back-to-back accepts give 16 consecutive results.
        pop0 = n_pop;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_instr = rnd_instr();
            in_pc    = $urandom;
            chk("thru_rdy", 32'(in_ready), 32'd1);
            cyc();
            chk("thru_vld", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        cyc();
        chk("thru_count", 32'(n_pop - pop0), 32'd16);
        chk("thru_empty", 32'(q.size()), 32'd0);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_instr  = rnd_instr();
            in_pc     = $urandom;
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("rand_drained", 32'(q.size()), 32'd0);
        chk("rand_idle", 32'(out_valid), 32'd0);

        // Asynchronous reset with M and K both full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFE000EE3;
        in_pc     = 32'h100;
        cyc();
        in_instr = 32'h008000EF;
        cyc();
        chk("mrst_full", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_imm", out_imm, 32'd0);
        chk("mrst_tgt", out_target, 32'd0);
        chk("mrst_fmt", 32'(out_fmt), 32'd0);
        chk("mrst_ready", 32'(in_ready), 32'd1);
        q.delete();
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_rdy_after", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (5) cyc();
        chk("mrst_no_stale", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
